// File: rtl/mem_ctrl_pkg.sv
// Shared bus widths, FSM state encoding and access-size codes for the
// byte-serial memory controller.
package mem_ctrl_pkg;

  localparam int INST_ADDR_W = 32;  // InstAddrBus
  localparam int REG_W       = 32;  // RegBus

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RD   = 2'd1,
    WR   = 2'd2,
    DONE = 2'd3
  } state_t;

  localparam logic [1:0] SIZE_B = 2'b00;
  localparam logic [1:0] SIZE_H = 2'b01;
  localparam logic [1:0] SIZE_W = 2'b10;

  localparam logic [1:0] IO_SEL_DEF = 2'b11;

  // Size code 11 falls through to a full word.
  function automatic logic [2:0] size_to_n(input logic [1:0] size);
    case (size)
      SIZE_B:  return 3'd1;
      SIZE_H:  return 3'd2;
      default: return 3'd4;
    endcase
  endfunction

endpackage

// File: rtl/mem_rd_assemble.sv
// Turns the little-endian read byte buffer into the 32-bit load result,
// zero- or sign-extending byte and half loads.
import mem_ctrl_pkg::*;

module mem_rd_assemble (
  input  logic [REG_W-1:0] bytes,
  input  logic [1:0]       size,
  input  logic             sgn,
  output logic [REG_W-1:0] data
);

  always_comb begin
    case (size)
      SIZE_B:  data = {{24{sgn & bytes[7]}}, bytes[7:0]};
      SIZE_H:  data = {{16{sgn & bytes[15]}}, bytes[15:0]};
      default: data = bytes;
    endcase
  end

endmodule

// File: rtl/mem_ctrl.sv
// Arbiter and byte-serial sequencer for the single 8-bit RAM/IO port shared
// by instruction fetch and the MEM stage.
import mem_ctrl_pkg::*;

module mem_ctrl #(
  parameter int         ADDR_W = INST_ADDR_W,
  parameter logic [1:0] IO_SEL = IO_SEL_DEF
) (
  input  logic              clk_in,
  input  logic              rst_n_in,
  input  logic              rdy_in,
  input  logic              if_req_in,
  input  logic [ADDR_W-1:0] if_addr_in,
  input  logic              if_flush_in,
  output logic              if_done_out,
  output logic [REG_W-1:0]  if_data_out,
  input  logic              mem_req_in,
  input  logic              mem_we_in,
  input  logic [ADDR_W-1:0] mem_addr_in,
  input  logic [1:0]        mem_size_in,
  input  logic              mem_signed_in,
  input  logic [REG_W-1:0]  mem_wdata_in,
  output logic              mem_done_out,
  output logic [REG_W-1:0]  mem_rdata_out,
  input  logic [7:0]        ram_din_in,
  output logic [7:0]        ram_dout_out,
  output logic [ADDR_W-1:0] ram_a_out,
  output logic              ram_wr_out,
  input  logic              io_buffer_full_in,
  output logic              busy_out
);

  state_t             state_q, state_d;
  logic               owner_mem_q;
  logic [ADDR_W-1:0]  base_q;
  logic [2:0]         n_q;
  logic [1:0]         size_q;
  logic               sgn_q;
  logic [REG_W-1:0]   wdata_q;
  logic [2:0]         cnt_q, cnt_d;
  logic [REG_W-1:0]   buf_q, buf_d;
  logic [REG_W-1:0]   if_data_q, mem_rdata_q;
  logic [REG_W-1:0]   asm_data;
  logic               accept_mem, accept_if;
  logic [2:0]         addr_idx;
  logic               throttled;
  logic               fill_done;

  mem_rd_assemble u_asm (
    .bytes (buf_d),
    .size  (size_q),
    .sgn   (sgn_q),
    .data  (asm_data)
  );

  always_comb begin
    state_d      = state_q;
    cnt_d        = cnt_q;
    buf_d        = buf_q;
    accept_mem   = 1'b0;
    accept_if    = 1'b0;
    addr_idx     = cnt_q;
    throttled    = 1'b0;
    fill_done    = 1'b0;
    ram_a_out    = '0;
    ram_dout_out = 8'h00;
    ram_wr_out   = 1'b0;
    case (state_q)
      IDLE: begin
        if (rdy_in) begin
          if (mem_req_in) begin
            accept_mem = 1'b1;
            state_d    = mem_we_in ? WR : RD;
            cnt_d      = 3'd0;
            buf_d      = '0;
          end else if (if_req_in && !if_flush_in) begin
            accept_if = 1'b1;
            state_d   = RD;
            cnt_d     = 3'd0;
            buf_d     = '0;
          end
        end
      end
      RD: begin
        // Hold the last issued address while draining or frozen, so the byte
        // on ram_din_in still belongs to index cnt-1 when sampling resumes.
        if (cnt_q == n_q || (!rdy_in && cnt_q != 3'd0))
          addr_idx = cnt_q - 3'd1;
        ram_a_out = base_q + ADDR_W'(addr_idx);
        if (rdy_in) begin
          if (!owner_mem_q && if_flush_in) begin
            state_d = IDLE;
            cnt_d   = 3'd0;
          end else begin
            case (cnt_q)
              3'd1:    buf_d[7:0]   = ram_din_in;
              3'd2:    buf_d[15:8]  = ram_din_in;
              3'd3:    buf_d[23:16] = ram_din_in;
              3'd4:    buf_d[31:24] = ram_din_in;
              default: ;
            endcase
            if (cnt_q == n_q) begin
              state_d   = DONE;
              fill_done = 1'b1;
            end else begin
              cnt_d = cnt_q + 3'd1;
            end
          end
        end
      end
      WR: begin
        ram_a_out = base_q + ADDR_W'(cnt_q);
        case (cnt_q)
          3'd0:    ram_dout_out = wdata_q[7:0];
          3'd1:    ram_dout_out = wdata_q[15:8];
          3'd2:    ram_dout_out = wdata_q[23:16];
          default: ram_dout_out = wdata_q[31:24];
        endcase
        throttled  = (ram_a_out[17:16] == IO_SEL) && io_buffer_full_in;
        ram_wr_out = rdy_in && !throttled;
        if (ram_wr_out) begin
          if (cnt_q == n_q - 3'd1) state_d = DONE;
          else                     cnt_d   = cnt_q + 3'd1;
        end
      end
      DONE: begin
        if (rdy_in) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk_in or negedge rst_n_in) begin
    if (!rst_n_in) begin
      state_q     <= IDLE;
      owner_mem_q <= 1'b0;
      base_q      <= '0;
      n_q         <= 3'd0;
      size_q      <= SIZE_B;
      sgn_q       <= 1'b0;
      wdata_q     <= '0;
      cnt_q       <= 3'd0;
      buf_q       <= '0;
      if_data_q   <= '0;
      mem_rdata_q <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      buf_q   <= buf_d;
      if (accept_mem) begin
        owner_mem_q <= 1'b1;
        base_q      <= mem_addr_in;
        n_q         <= size_to_n(mem_size_in);
        size_q      <= mem_size_in;
        sgn_q       <= mem_signed_in;
        wdata_q     <= mem_wdata_in;
      end else if (accept_if) begin
        owner_mem_q <= 1'b0;
        base_q      <= if_addr_in;
        n_q         <= 3'd4;
        size_q      <= SIZE_W;
        sgn_q       <= 1'b0;
        wdata_q     <= '0;
      end
      if (fill_done) begin
        if (owner_mem_q) mem_rdata_q <= asm_data;
        else             if_data_q   <= asm_data;
      end
    end
  end

  assign if_done_out   = (state_q == DONE) && rdy_in && !owner_mem_q && !if_flush_in;
  assign mem_done_out  = (state_q == DONE) && rdy_in && owner_mem_q;
  assign if_data_out   = if_data_q;
  assign mem_rdata_out = mem_rdata_q;
  assign busy_out      = (state_q != IDLE);

endmodule

// File: tb/tb_mem_ctrl.sv
// Directed bench for mem_ctrl: a byte RAM model, a table of single
// transactions and hand-written multi-cycle sequences.
module tb_mem_ctrl;
  import mem_ctrl_pkg::*;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        rdy;
  logic        if_req;
  logic [31:0] if_addr;
  logic        if_flush;
  logic        if_done;
  logic [31:0] if_data;
  logic        mem_req;
  logic        mem_we;
  logic [31:0] mem_addr;
  logic [1:0]  mem_size;
  logic        mem_signed;
  logic [31:0] mem_wdata;
  logic        mem_done;
  logic [31:0] mem_rdata;
  logic [7:0]  ram_din = 8'h00;
  logic [7:0]  ram_dout;
  logic [31:0] ram_a;
  logic        ram_wr;
  logic        io_full;
  logic        busy;

  int tests = 0;
  int fails = 0;

  always #5 clk = ~clk;

  mem_ctrl dut (
    .clk_in            (clk),
    .rst_n_in          (rst_n),
    .rdy_in            (rdy),
    .if_req_in         (if_req),
    .if_addr_in        (if_addr),
    .if_flush_in       (if_flush),
    .if_done_out       (if_done),
    .if_data_out       (if_data),
    .mem_req_in        (mem_req),
    .mem_we_in         (mem_we),
    .mem_addr_in       (mem_addr),
    .mem_size_in       (mem_size),
    .mem_signed_in     (mem_signed),
    .mem_wdata_in      (mem_wdata),
    .mem_done_out      (mem_done),
    .mem_rdata_out     (mem_rdata),
    .ram_din_in        (ram_din),
    .ram_dout_out      (ram_dout),
    .ram_a_out         (ram_a),
    .ram_wr_out        (ram_wr),
    .io_buffer_full_in (io_full),
    .busy_out          (busy)
  );

  // Byte RAM: read data appears the cycle after its address.
  logic [7:0] ram [logic [31:0]];
  always @(posedge clk) begin
    ram_din <= ram.exists(ram_a) ? ram[ram_a] : 8'h00;
    if (ram_wr) ram[ram_a] = ram_dout;
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  typedef struct {
    logic        is_if;
    logic        we;
    logic [1:0]  size;
    logic        sgn;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [31:0] exp;
    int          lat;
    string       name;
  } vec_t;

  vec_t vecs[12];

  function automatic int nbytes(input vec_t v);
    if (v.is_if) return 4;
    case (v.size)
      SIZE_B:  return 1;
      SIZE_H:  return 2;
      default: return 4;
    endcase
  endfunction

  function automatic logic [31:0] ram_word(input logic [31:0] a, input int n);
    logic [31:0] w = 32'h0;
    for (int j = 0; j < n; j++)
      w[8*j +: 8] = ram.exists(a + 32'(j)) ? ram[a + 32'(j)] : 8'h00;
    return w;
  endfunction

  task automatic idle_inputs();
    if_req = 1'b0; if_flush = 1'b0; mem_req = 1'b0; mem_we = 1'b0;
    mem_size = SIZE_B; mem_signed = 1'b0; mem_wdata = 32'h0; io_full = 1'b0;
  endtask

  // Starts at a negedge; returns the cycle index of the done pulse.
  task automatic do_txn(input vec_t v, output int lat, output logic [31:0] data);
    int n = nbytes(v);
    for (int j = 0; j < n; j++)
      ram[v.addr + 32'(j)] = v.we ? 8'h00 : v.wdata[8*j +: 8];
    if (v.is_if) begin
      if_req = 1'b1; if_addr = v.addr;
    end else begin
      mem_req = 1'b1; mem_we = v.we; mem_addr = v.addr;
      mem_size = v.size; mem_signed = v.sgn; mem_wdata = v.wdata;
    end
    lat = 0;
    data = 32'hx;
    while (lat < 40) begin
      @(negedge clk);
      lat++;
      if (v.is_if ? if_done : mem_done) begin
        data = v.is_if ? if_data : mem_rdata;
        break;
      end
    end
    idle_inputs();
    @(negedge clk);
  endtask

  initial begin
    int lat;
    int k_mem;
    int k_if;
    logic [31:0] data;
    logic [31:0] d_mem;
    logic [31:0] a_t8;
    logic        seen;

    #200000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

  initial begin
    int lat, k_mem, k_if;
    logic [31:0] data, d_mem, a_t8;
    logic seen;

    vecs[0]  = '{1'b1, 1'b0, SIZE_W, 1'b0, 32'h0000_0010, 32'h0000_0513, 32'h0000_0513, 6, "if_fetch"};
    vecs[1]  = '{1'b0, 1'b0, SIZE_W, 1'b0, 32'h0000_0100, 32'hDEAD_BEEF, 32'hDEAD_BEEF, 6, "lw"};
    vecs[2]  = '{1'b0, 1'b0, SIZE_B, 1'b1, 32'h0000_0040, 32'h0000_0080, 32'hFFFF_FF80, 3, "lb"};
    vecs[3]  = '{1'b0, 1'b0, SIZE_B, 1'b0, 32'h0000_0041, 32'h0000_0080, 32'h0000_0080, 3, "lbu"};
    vecs[4]  = '{1'b0, 1'b0, SIZE_H, 1'b1, 32'h0000_0050, 32'h0000_8001, 32'hFFFF_8001, 4, "lh"};
    vecs[5]  = '{1'b0, 1'b0, SIZE_H, 1'b0, 32'h0000_0052, 32'h0000_8001, 32'h0000_8001, 4, "lhu"};
    vecs[6]  = '{1'b0, 1'b0, SIZE_H, 1'b1, 32'h0000_0054, 32'h0000_7FFE, 32'h0000_7FFE, 4, "lh_pos"};
    vecs[7]  = '{1'b0, 1'b1, SIZE_W, 1'b0, 32'h0000_0200, 32'h1122_3344, 32'h1122_3344, 5, "sw"};
    vecs[8]  = '{1'b0, 1'b1, SIZE_H, 1'b0, 32'h0000_0300, 32'h5555_ABCD, 32'h0000_ABCD, 3, "sh"};
    vecs[9]  = '{1'b0, 1'b0, SIZE_W, 1'b0, 32'hFFFF_FFFE, 32'h0403_0201, 32'h0403_0201, 6, "lw_wrap"};
    vecs[10] = '{1'b0, 1'b0, 2'b11,  1'b0, 32'h0000_0120, 32'hCAFE_F00D, 32'hCAFE_F00D, 6, "lw_size11"};
    vecs[11] = '{1'b0, 1'b1, SIZE_B, 1'b0, 32'h0000_0310, 32'h0000_00A5, 32'h0000_00A5, 2, "sb"};

    idle_inputs();
    if_addr = 32'h0; mem_addr = 32'h0;
    rdy = 1'b1;
    rst_n = 1'b0;
    repeat (3) @(negedge clk);
    check("rst_busy", 32'(busy), 32'h0);
    check("rst_ram_wr", 32'(ram_wr), 32'h0);
    check("rst_ram_a", ram_a, 32'h0);
    check("rst_dones", {30'h0, if_done, mem_done}, 32'h0);
    check("rst_if_data", if_data, 32'h0);
    check("rst_mem_rdata", mem_rdata, 32'h0);
    rst_n = 1'b1;
    @(negedge clk);

    foreach (vecs[i]) begin
      do_txn(vecs[i], lat, data);
      check({vecs[i].name, "_lat"}, 32'(lat), 32'(vecs[i].lat));
      if (vecs[i].we)
        check({vecs[i].name, "_ram"}, ram_word(vecs[i].addr, nbytes(vecs[i])), vecs[i].exp);
      else
        check({vecs[i].name, "_data"}, data, vecs[i].exp);
    end

    // Simultaneous requests: MEM first, IF accepted in the IDLE cycle after DONE.
    ram[32'h10] = 8'h13; ram[32'h11] = 8'h05; ram[32'h12] = 8'h00; ram[32'h13] = 8'h00;
    ram[32'h100] = 8'hEF; ram[32'h101] = 8'hBE; ram[32'h102] = 8'hAD; ram[32'h103] = 8'hDE;
    if_req = 1'b1; if_addr = 32'h10;
    mem_req = 1'b1; mem_we = 1'b0; mem_addr = 32'h100; mem_size = SIZE_W; mem_signed = 1'b0;
    k_mem = 0; k_if = 0; d_mem = 32'h0; a_t8 = 32'h0; data = 32'h0;
    for (int k = 1; k <= 30; k++) begin
      @(negedge clk);
      if (k == 8) a_t8 = ram_a;
      if (mem_done) begin k_mem = k; d_mem = mem_rdata; mem_req = 1'b0; end
      if (if_done) begin k_if = k; data = if_data; if_req = 1'b0; break; end
    end
    idle_inputs();
    check("arb_mem_lat", 32'(k_mem), 32'd6);
    check("arb_mem_data", d_mem, 32'hDEAD_BEEF);
    check("arb_if_lat", 32'(k_if), 32'd13);
    check("arb_if_addr", a_t8, 32'h10);
    check("arb_if_data", data, 32'h0000_0513);
    @(negedge clk);

    // IO throttle: buffer full through t1..t3, single write in t4, done in t5.
    mem_req = 1'b1; mem_we = 1'b1; mem_addr = 32'h0003_0000; mem_size = SIZE_B;
    mem_wdata = 32'h0000_0041; io_full = 1'b1;
    ram[32'h0003_0000] = 8'h00;
    for (int k = 1; k <= 3; k++) begin
      @(negedge clk);
      check("io_hold_wr", 32'(ram_wr), 32'h0);
    end
    @(posedge clk); #1 io_full = 1'b0;
    @(negedge clk);
    check("io_write", {23'h0, ram_wr, ram_dout}, {23'h0, 1'b1, 8'h41});
    @(negedge clk);
    check("io_done", {30'h0, mem_done, ram_wr}, {30'h0, 1'b1, 1'b0});
    idle_inputs();
    @(negedge clk);
    check("io_ram", 32'(ram[32'h0003_0000]), 32'h41);

    // rdy low for two whole cycles mid-read: done at t8 instead of t6.
    mem_req = 1'b1; mem_we = 1'b0; mem_addr = 32'h100; mem_size = SIZE_W;
    @(negedge clk);
    @(posedge clk); #1 rdy = 1'b0;
    @(posedge clk); #1;
    check("frz_wr", 32'(ram_wr), 32'h0);
    @(posedge clk); #1 rdy = 1'b1;
    lat = 3; data = 32'h0;
    while (lat < 40) begin
      @(negedge clk);
      lat++;
      if (mem_done) begin data = mem_rdata; break; end
    end
    idle_inputs();
    check("frz_lat", 32'(lat), 32'd8);
    check("frz_data", data, 32'hDEAD_BEEF);
    @(negedge clk);

    // Flush in t2 aborts the fetch; pending load accepted at the end of t3.
    if_req = 1'b1; if_addr = 32'h10;
    @(negedge clk);
    @(negedge clk);
    if_flush = 1'b1;
    mem_req = 1'b1; mem_we = 1'b0; mem_addr = 32'h100; mem_size = SIZE_W;
    @(negedge clk);
    check("flush_busy", {30'h0, busy, if_done}, 32'h0);
    if_flush = 1'b0; if_req = 1'b0;
    lat = 0; seen = 1'b0; data = 32'h0;
    while (lat < 40) begin
      @(negedge clk);
      lat++;
      if (if_done) seen = 1'b1;
      if (mem_done) begin data = mem_rdata; break; end
    end
    idle_inputs();
    check("flush_mem_lat", 32'(lat), 32'd6);
    check("flush_mem_data", data, 32'hDEAD_BEEF);
    check("flush_no_if_done", 32'(seen), 32'h0);
    @(negedge clk);

    // Flush during DONE masks if_done.
    ram[32'h10] = 8'h77;
    if_req = 1'b1; if_addr = 32'h10;
    repeat (5) @(negedge clk);
    @(posedge clk); #1 if_flush = 1'b1;
    #2;
    check("dflush_done", {30'h0, busy, if_done}, {30'h0, 1'b1, 1'b0});
    @(posedge clk); #1 idle_inputs();
    @(negedge clk);
    check("dflush_idle", 32'(busy), 32'h0);

    // Asynchronous reset in the middle of a store.
    mem_req = 1'b1; mem_we = 1'b1; mem_addr = 32'h200; mem_size = SIZE_W;
    mem_wdata = 32'h5566_7788;
    @(negedge clk);
    @(negedge clk);
    check("mid_wr", 32'(ram_wr), 32'h1);
    #1 rst_n = 1'b0;
    #1;
    check("mid_rst", {30'h0, ram_wr, busy}, 32'h0);
    check("mid_rst_rdata", mem_rdata, 32'h0);
    idle_inputs();
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/mem_ctrl.md
Name: mem_ctrl

Overview:
- Byte-serial memory controller and arbiter for the CPU's single 8-bit RAM/IO port.
- Shares the port between the instruction-fetch requester (pc_reg/if_id path) and the MEM-stage requester (load/store).
- Splits word, half and byte accesses into per-byte cycles and assembles read data, with sign extension where requested.
- Throttles UART writes on io_buffer_full.

Parameters:
- ADDR_W, 32: address width of the requester buses and the RAM address bus.
- IO_SEL, 2'b11: value of addr[17:16] that selects I/O space.

Ports:
- clk_in  in  1  system clock
- rst_n_in  in  1  asynchronous, active-low reset
- rdy_in  in  1  global ready; low freezes the block
- if_req_in  in  1  fetch request, level, held until if_done_out
- if_addr_in  in  ADDR_W  fetch address (always a 4-byte read)
- if_flush_in  in  1  abort the pending or active fetch (branch taken)
- if_done_out  out  1  one-cycle pulse; if_data_out valid
- if_data_out  out  32  fetched instruction, little-endian
- mem_req_in  in  1  load/store request, level, held until mem_done_out
- mem_we_in  in  1  1 = store
- mem_addr_in  in  ADDR_W  byte address
- mem_size_in  in  2  00 = byte, 01 = half, 10 = word (11 is treated as word)
- mem_signed_in  in  1  sign-extend byte/half loads
- mem_wdata_in  in  32  store data; low bytes are used first
- mem_done_out  out  1  one-cycle pulse; mem_rdata_out valid
- mem_rdata_out  out  32  load result
- ram_din_in  in  8  RAM/IO read byte; valid the cycle after its address
- ram_dout_out  out  8  write byte
- ram_a_out  out  ADDR_W  byte address
- ram_wr_out  out  1  1 = write
- io_buffer_full_in  in  1  UART buffer full
- busy_out  out  1  state != IDLE

Behaviour:
- Reset (rst_n_in low, asynchronous): state is IDLE; all outputs, byte counter and assembly register are 0.
- States: IDLE, RD, WR, DONE. N = byte count: 1, 2 or 4; fetch N = 4.
- IDLE: on an edge with rdy_in = 1, the block accepts a request.
  - Priority: mem_req_in over if_req_in.
  - If if_flush_in is high, an IF request is not accepted.
  - On accept it latches owner, base address, N, we, signed and wdata, and sets cnt = 0.
  - Next state is WR if we = 1, otherwise RD.
- Accept cycle t0; issue cycles t1..tN. In each issue cycle:
  - ram_a_out = base + k, where k = issue index.
  - RD: ram_wr_out = 0.
  - WR: ram_wr_out = 1 and ram_dout_out = wdata byte k.
- RD timing: byte k is sampled from ram_din_in in cycle t(k+2). State is RD through t(N+1), then DONE in t(N+2).
  - ram_a_out holds the last address during the drain cycle.
- WR timing: DONE follows tN, i.e. in t(N+1).
- DONE: exactly one cycle.
  - The owner's done pulse is high and the data output is valid; the data output holds its value until the next done.
  - Next state is IDLE.
  - A new request cannot be accepted during DONE.
  - Requesters drop req on the edge that ends DONE.
- Read assembly: little-endian.
  - Unsigned byte/half loads are zero-extended.
  - Signed loads are sign-extended from bit 7 or bit 15.
- IO throttle: in WR, when ram_a_out[17:16] == IO_SEL and io_buffer_full_in = 1:
  - ram_wr_out is forced to 0;
  - cnt does not advance;
  - the byte is re-issued each cycle until full deasserts.
  - Reads are never throttled.
- rdy_in = 0: state, counters and registers are frozen; ram_wr_out is forced to 0; done pulses are delayed, never dropped.
- if_flush_in = 1 while the owner is IF in RD: abort to IDLE next edge, no if_done_out.
  - Flush in the DONE cycle masks if_done_out to 0.
  - Flush has no effect on MEM transactions; stores are never aborted.
- Requests arriving while busy wait. No starvation guarantee is needed because the pipeline holds IF while MEM is outstanding.
- Address arithmetic wraps modulo 2^ADDR_W.
- Mid-transaction reset: immediate return to IDLE; ram_wr_out goes to 0 asynchronously.

Decomposition:
- Shared defines package: state encodings, size codes (SIZE_B/H/W), IO_SEL.
  - Add them alongside the existing InstAddrBus/RegBus defines.
- One sub-module, mem_rd_assemble (combinational): takes the byte buffer, size and signed flag and produces the extended 32-bit result.
- The FSM, arbiter and counters stay in mem_ctrl.

Test Plan:
- IF read of 0x00000010, RAM bytes 13 05 00 00: accept at t0, addresses 0x10..0x13 in t1..t4, if_done_out in t6 with if_data_out = 0x00000513.
- Simultaneous if_req and mem_req (lw 0x100 = 0xDEADBEEF): MEM served first, mem_rdata_out = 0xDEADBEEF; IF accepted on the first IDLE cycle after DONE.
- lb from a byte 0x80, signed: mem_rdata_out = 0xFFFFFF80. Unsigned: 0x00000080. lh of 0x8001 signed gives 0xFFFF8001.
- sw 0x11223344 to 0x200: ram_wr_out high t1..t4, data 44 33 22 11 at addresses 0x200..0x203, mem_done_out in t5.
- sb 0x41 to 0x30000 with io_buffer_full_in high for 3 cycles: ram_wr_out stays 0 for those 3 cycles, a single write follows, done one cycle after it. Also: rdy_in low for 2 cycles mid-read extends the done latency by exactly 2.
- if_flush_in asserted in t2 of a fetch: no if_done_out, busy_out low from t3; an immediately pending mem_req is accepted at the t3 edge.
